fpga_scan_ctrl: RTL

FPGA-side sequencer for the ISFET readout chip. It serialises an 18-bit command word to the chip and waits for conversions on the chip's SPI return path. It averages 2^avg_log2 signed ADC conversions per pixel and hands each result to the UART block over a valid/ready interface. Supports single-pixel mode and auto-scan over a pixel range, with a wait-for-data timeout, abort, and per-run settle codes.

---
 rtl/fpga_scan_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fpga_scan_ctrl.sv
// Sequencer for the ISFET readout chip: shifts out a command word, collects
// signed ADC conversions, averages them and presents one result per pixel.
module fpga_scan_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int SETTLE_BITS  = 4,
  parameter int CMD_WIDTH    = 18,
  parameter int ADC_BITS     = 18,
  parameter int AVG_LOG2_MAX = 3,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic                   clk_ext,
  input  logic                   rstb_ext,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   scan_mode,
  input  logic [ADDR_WIDTH-1:0]  pix_first,
  input  logic [ADDR_WIDTH-1:0]  pix_last,
  input  logic [SETTLE_BITS-1:0] settle_pre,
  input  logic [SETTLE_BITS-1:0] settle_post,
  input  logic                   rotate_flag,
  input  logic                   adc_int_flag,
  input  logic [1:0]             avg_log2,
  input  logic                   spi_si4chip_ena,
  input  logic                   din_4_chip,
  output logic                   dout_2_chip,
  output logic                   spi_so2chip_flag,
  output logic                   spi_fpga_wait,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ADDR_WIDTH-1:0]  res_pixel,
  output logic [ADC_BITS-1:0]    res_data,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err
);

  localparam int CNT_W = $clog2(CMD_WIDTH);
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam int ACC_W = ADC_BITS + AVG_LOG2_MAX;
  localparam int SMP_W = AVG_LOG2_MAX + 1;
  localparam logic [1:0]       AVG_MAX  = 2'(AVG_LOG2_MAX);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CMD_WIDTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEROUT, S_WFD, S_SERIN, S_ACCUM, S_EMIT
  } state_t;

  state_t                  r_state;
  logic                    r_din_q;
  logic                    r_scan, r_rot, r_adc;
  logic [ADDR_WIDTH-1:0]   r_pix, r_last;
  logic [SETTLE_BITS-1:0]  r_pre, r_post;
  logic [1:0]              r_avg;
  logic [CMD_WIDTH-1:0]    r_cmd;
  logic [CNT_W-1:0]        r_bit;
  logic [TO_W-1:0]         r_to;
  logic [ADC_BITS-1:0]     r_sin;
  logic signed [ACC_W-1:0] r_acc;
  logic [SMP_W-1:0]        r_smp;

  logic signed [ACC_W-1:0] w_sext, w_sum, w_avgd;
  logic [SMP_W-1:0]        w_smp_nxt, w_smp_tgt;
  logic [1:0]              w_avg_clamp;

  assign w_avg_clamp = (avg_log2 > AVG_MAX) ? AVG_MAX : avg_log2;
  assign w_sext      = {{AVG_LOG2_MAX{r_sin[ADC_BITS-1]}}, r_sin};
  assign w_sum       = r_acc + w_sext;
  assign w_avgd      = w_sum >>> r_avg;
  assign w_smp_nxt   = r_smp + SMP_W'(1);
  assign w_smp_tgt   = SMP_W'(1) << r_avg;

  assign busy          = (r_state != S_IDLE);
  assign spi_fpga_wait = (r_state == S_WFD);

  always_ff @(posedge clk_ext or negedge rstb_ext)
    if (!rstb_ext) r_din_q <= 1'b0;
    else           r_din_q <= din_4_chip;

  always_ff @(posedge clk_ext or negedge rstb_ext) begin
    if (!rstb_ext) begin
      r_state          <= S_IDLE;
      r_scan           <= 1'b0;
      r_rot            <= 1'b0;
      r_adc            <= 1'b0;
      r_pix            <= '0;
      r_last           <= '0;
      r_pre            <= '0;
      r_post           <= '0;
      r_avg            <= '0;
      r_cmd            <= '0;
      r_bit            <= '0;
      r_to             <= '0;
      r_sin            <= '0;
      r_acc            <= '0;
      r_smp            <= '0;
      dout_2_chip      <= 1'b0;
      spi_so2chip_flag <= 1'b0;
      res_valid        <= 1'b0;
      res_pixel        <= '0;
      res_data         <= '0;
      done             <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && r_state != S_IDLE) begin
        // Abort drops any pending result; timeout_err is left as-is.
        r_state          <= S_IDLE;
        dout_2_chip      <= 1'b0;
        spi_so2chip_flag <= 1'b0;
        res_valid        <= 1'b0;
        res_pixel        <= '0;
        res_data         <= '0;
        done             <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            r_scan      <= scan_mode;
            r_last      <= pix_last;
            r_pre       <= settle_pre;
            r_post      <= settle_post;
            r_rot       <= rotate_flag;
            r_adc       <= adc_int_flag;
            r_avg       <= w_avg_clamp;
            r_pix       <= pix_first;
            timeout_err <= 1'b0;
            r_state     <= S_LOAD;
          end
          S_LOAD: begin
            r_cmd            <= {r_rot, r_adc, r_post, r_pre, r_pix};
            spi_so2chip_flag <= 1'b1;
            r_acc            <= '0;
            r_smp            <= '0;
            r_bit            <= '0;
            r_to             <= '0;
            r_state          <= S_SEROUT;
          end
          S_SEROUT: begin
            dout_2_chip <= r_cmd[CMD_WIDTH-1];
            r_cmd       <= {r_cmd[CMD_WIDTH-2:0], 1'b0};
            r_bit       <= r_bit + CNT_W'(1);
            if (r_bit == BIT_LAST) begin
              spi_so2chip_flag <= 1'b0;
              r_state          <= S_WFD;
            end
          end
          S_WFD: begin
            dout_2_chip <= 1'b0;
            if (spi_si4chip_ena) begin
              r_to    <= '0;
              r_state <= S_SERIN;
            end else if (r_to == TO_LAST) begin
              r_to        <= '0;
              timeout_err <= 1'b1;
              done        <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_to <= r_to + TO_W'(1);
            end
          end
          // din_q lags the chip by a cycle, so the shift also runs on the
          // cycle where ena has already dropped to pick up the last bit.
          S_SERIN: begin
            r_sin <= {r_sin[ADC_BITS-2:0], r_din_q};
            if (!spi_si4chip_ena) r_state <= S_ACCUM;
          end
          S_ACCUM: begin
            r_acc <= w_sum;
            r_smp <= w_smp_nxt;
            if (w_smp_nxt == w_smp_tgt) begin
              res_data  <= w_avgd[ADC_BITS-1:0];
              res_pixel <= r_pix;
              res_valid <= 1'b1;
              r_state   <= S_EMIT;
            end else begin
              r_state <= S_WFD;
            end
          end
          S_EMIT: if (res_ready) begin
            res_valid <= 1'b0;
            if (!r_scan || r_pix == r_last) begin
              done    <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_pix   <= r_pix + ADDR_WIDTH'(1);
              r_state <= S_LOAD;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
